game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_pkg.sv | 19 +
 rtl/game_ctrl_btn_debounce.sv | 57 +++++
 rtl/game_ctrl.sv | 135 +++++++++++++
 tb/tb_game_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared game definitions: status encodings seen by game_ctrl and the renderer,
// plus the score saturation helper.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD      = 2'b00,
    ST_ACTIVATE  = 2'b01,
    ST_PAUSE     = 2'b10,
    ST_TERMINATE = 2'b11
  } game_state_t;

  localparam logic [15:0] SCORE_MAX = 16'hFFFF;

  // Increment that sticks at the top value instead of wrapping to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == SCORE_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/game_ctrl_btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, stability-window debouncer
// and a one-cycle press pulse on each debounced 0->1 transition.
module btn_debounce
  import game_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new level only after it has differed from the stable value for
  // DB_CYCLES consecutive cycles; any return to the stable value restarts it.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
    end else if (sync2_reg == stable_reg) begin
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg    <= '0;
      stable_reg <= ~stable_reg;
      // Only the low-to-high toggle is a press; releases stay silent.
      press_reg  <= ~stable_reg;
    end else begin
      cnt_reg   <= cnt_reg + 1'b1;
      press_reg <= 1'b0;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/game_ctrl.sv
// Game state controller: conditions buttons, crash and vsync, latches button
// presses until the next frame boundary, and steps the game FSM and frame
// score once per frame.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        crash,
  input  logic        vsync,
  output logic [1:0]  status,
  output logic [15:0] score,
  output logic        frame_tick
);

  logic        start_press;
  logic        pause_press;
  logic        crash_sync1_reg;
  logic        crash_sync2_reg;
  logic        vs_sync1_reg;
  logic        vs_sync2_reg;
  logic        vs_prev_reg;
  logic        boundary;
  logic        start_pend_reg;
  logic        pause_pend_reg;
  game_state_t state_reg;
  logic [15:0] score_reg;
  logic        frame_tick_reg;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk   (clk),
    .clr   (clr),
    .btn   (btn_start),
    .press (start_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause (
    .clk   (clk),
    .clr   (clr),
    .btn   (btn_pause),
    .press (pause_press)
  );

  // Synchronize the crash level from the game logic.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      crash_sync1_reg <= 1'b0;
      crash_sync2_reg <= 1'b0;
    end else begin
      crash_sync1_reg <= crash;
      crash_sync2_reg <= crash_sync1_reg;
    end
  end

  // Synchronize vsync; flops reset high so reset release never looks like a fall.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      vs_sync1_reg <= 1'b1;
      vs_sync2_reg <= 1'b1;
      vs_prev_reg  <= 1'b1;
    end else begin
      vs_sync1_reg <= vsync;
      vs_sync2_reg <= vs_sync1_reg;
      vs_prev_reg  <= vs_sync2_reg;
    end
  end

  assign boundary = vs_prev_reg & ~vs_sync2_reg;

  // Hold presses until the next boundary; a press landing on the boundary
  // cycle itself survives into the following frame.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      start_pend_reg <= 1'b0;
      pause_pend_reg <= 1'b0;
    end else if (boundary) begin
      start_pend_reg <= start_press;
      pause_pend_reg <= pause_press;
    end else begin
      if (start_press) start_pend_reg <= 1'b1;
      if (pause_press) pause_pend_reg <= 1'b1;
    end
  end

  // Game FSM, score and frame tick, all updated from the boundary cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg      <= ST_LOAD;
      score_reg      <= 16'd0;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= boundary;
      if (boundary) begin
        case (state_reg)
          ST_LOAD: begin
            if (start_pend_reg) begin
              state_reg <= ST_ACTIVATE;
              score_reg <= 16'd0;
            end
          end
          ST_ACTIVATE: begin
            // Crash wins over a pause requested in the same frame.
            if (crash_sync2_reg) begin
              state_reg <= ST_TERMINATE;
            end else if (pause_pend_reg) begin
              state_reg <= ST_PAUSE;
            end else begin
              score_reg <= sat_inc(score_reg);
            end
          end
          ST_PAUSE: begin
            if (pause_pend_reg || start_pend_reg) begin
              state_reg <= ST_ACTIVATE;
            end
          end
          ST_TERMINATE: begin
            if (start_pend_reg) begin
              state_reg <= ST_LOAD;
            end
          end
          default: state_reg <= ST_LOAD;
        endcase
      end
    end
  end

  assign status     = state_reg;
  assign score      = score_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Frame-level bench for game_ctrl: each frame's presses and crash level are
// applied to a per-frame reference model of the game rules.
module tb_game_ctrl;

  localparam int DB = 4;
  localparam logic [1:0] M_LOAD  = 2'b00;
  localparam logic [1:0] M_ACT   = 2'b01;
  localparam logic [1:0] M_PAUSE = 2'b10;
  localparam logic [1:0] M_TERM  = 2'b11;

  logic        clk = 1'b0;
  logic        clr;
  logic        btn_start;
  logic        btn_pause;
  logic        crash;
  logic        vsync;
  logic [1:0]  status;
  logic [15:0] score;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int frame_no = 0;
  int start_pulses = 0;

  logic [1:0] m_state;
  int         m_score;
  bit         m_carry_start;

  always #5 clk = ~clk;

  game_ctrl #(.DB_CYCLES(DB)) dut (
    .clk        (clk),
    .clr        (clr),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .crash      (crash),
    .vsync      (vsync),
    .status     (status),
    .score      (score),
    .frame_tick (frame_tick)
  );

  always @(posedge clk) begin
    if (dut.start_press) start_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Game rules applied once per frame to the presses seen in that frame.
  task automatic model_boundary(input bit sp, input bit pp, input bit cr);
    case (m_state)
      M_LOAD:  if (sp) begin m_state = M_ACT; m_score = 0; end
      M_ACT: begin
        if (cr)      m_state = M_TERM;
        else if (pp) m_state = M_PAUSE;
        else if (m_score < 65535) m_score = m_score + 1;
      end
      M_PAUSE: if (sp || pp) m_state = M_ACT;
      default: if (sp) m_state = M_LOAD;
    endcase
  endtask

  task automatic drive_btn(input bit which, input logic v);
    if (which) btn_pause = v;
    else       btn_start = v;
  endtask

  task automatic press_btn(input bit which, input bit bounce);
    if (bounce) begin
      for (int k = 0; k < 4; k++) begin
        drive_btn(which, (k % 2 == 0) ? 1'b1 : 1'b0);
        repeat (2) @(negedge clk);
      end
    end
    drive_btn(which, 1'b1);
    repeat (10) @(negedge clk);
    drive_btn(which, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  // One frame: optional presses mid-frame, then a vsync fall and checks of
  // the tick and status/score around the expected update cycle.
  task automatic frame(input bit sp, input bit pp, input bit cr, input bit bounce, input bit late);
    bit         eff_sp;
    logic [1:0] prev_state;
    int         prev_score;
    eff_sp = sp | m_carry_start;
    @(negedge clk);
    crash = cr;
    repeat (4) @(negedge clk);
    if (sp) press_btn(1'b0, bounce);
    if (pp) press_btn(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    if (late) begin
      btn_start = 1'b1;
      repeat (4) @(negedge clk);
    end
    vsync = 1'b0;
    prev_state = m_state;
    prev_score = m_score;
    model_boundary(eff_sp, pp, cr);
    m_carry_start = late;
    frame_no++;
    @(posedge clk); #1;
    check("tick_e1", frame_tick, 0);
    @(posedge clk); #1;
    check("tick_e2", frame_tick, 0);
    check("status_e2", status, prev_state);
    check("score_e2", score, prev_score);
    @(posedge clk); #1;
    check("tick_e3", frame_tick, 1);
    check("status_e3", status, m_state);
    check("score_e3", score, m_score);
    @(posedge clk); #1;
    check("tick_e4", frame_tick, 0);
    check("status_e4", status, m_state);
    $display("frame %0d: sp=%0d pp=%0d crash=%0d late=%0d -> status=%0d score=%0d",
             frame_no, sp, pp, cr, late, status, score);
    @(negedge clk);
    vsync = 1'b1;
    btn_start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    check("clr_status", status, M_LOAD);
    check("clr_score", score, 0);
    check("clr_tick", frame_tick, 0);
    m_state = M_LOAD;
    m_score = 0;
    m_carry_start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    clr = 1'b0;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    crash = 1'b0;
    vsync = 1'b1;
    m_state = M_LOAD;
    m_score = 0;
    m_carry_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_status", status, M_LOAD);
    check("rst_score", score, 0);
    check("rst_tick", frame_tick, 0);
    clr = 1'b1;
    repeat (3) @(negedge clk);

    // Idle frames stay in load.
    repeat (3) frame(0, 0, 0, 0, 0);
    check("idle_status", status, M_LOAD);

    // Start, then five frames of play.
    frame(1, 0, 0, 0, 0);
    check("start_status", status, M_ACT);
    repeat (5) frame(0, 0, 0, 0, 0);
    check("score5", score, 5);

    // Pause and crash in the same frame: crash wins, score frozen.
    frame(0, 1, 1, 0, 0);
    check("crash_status", status, M_TERM);
    frame(0, 0, 0, 0, 0);
    check("term_score", score, 5);
    frame(1, 0, 0, 0, 0);
    check("restart_status", status, M_LOAD);

    // Bouncy start gives a single press.
    base = start_pulses;
    frame(1, 0, 0, 1, 0);
    check("bounce_pulses", start_pulses - base, 1);
    check("bounce_status", status, M_ACT);

    // Pause for three frames, then resume.
    frame(0, 1, 0, 0, 0);
    check("pause_status", status, M_PAUSE);
    repeat (3) frame(0, 0, 0, 0, 0);
    check("pause_score", score, 0);
    frame(0, 1, 0, 0, 0);
    check("resume_status", status, M_ACT);
    frame(0, 0, 0, 0, 0);
    check("resume_score", score, 1);

    // Press landing on the boundary cycle is carried to the next frame.
    frame(0, 0, 1, 0, 0);
    frame(0, 0, 0, 0, 1);
    check("late_hold", status, M_TERM);
    frame(0, 0, 0, 0, 0);
    check("late_carry", status, M_LOAD);

    // Saturation near the top of the score range, then mid-game reset.
    frame(1, 0, 0, 0, 0);
    @(negedge clk);
    force dut.score_reg = 16'hFFFE;
    @(posedge clk); #1;
    release dut.score_reg;
    m_score = 65534;
    check("preload", score, 16'hFFFE);
    repeat (3) frame(0, 0, 0, 0, 0);
    check("sat_score", score, 16'hFFFF);
    pulse_clr();

    // Randomized frames against the model.
    for (int i = 0; i < 40; i++) begin
      frame($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
